// File: rtl/alu.sv
// 8-bit ALU: combinational operation core feeding a registered result and
// carry/zero/negative/overflow status for writeback and branch logic.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NAND = 4'h5,
        OP_NOR  = 4'h6,
        OP_XNOR = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_INC  = 4'hC,
        OP_DEC  = 4'hD,
        OP_NOT  = 4'hE,
        OP_PASS = 4'hF
    } op_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;
    op_t              w_op;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_negative;
    logic             r_overflow;

    // The extra top bit of the 9-bit difference is the unsigned borrow (a < b).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_op   = op_t'(alu_sel);

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_result   = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_NAND: w_result = ~(a & b);
            OP_NOR:  w_result = ~(a | b);
            OP_XNOR: w_result = ~(a ^ b);
            OP_SHL: begin
                w_result = {a[WIDTH-2:0], 1'b0};
                w_carry  = a[WIDTH-1];
            end
            OP_SHR: begin
                w_result = {1'b0, a[WIDTH-1:1]};
                w_carry  = a[0];
            end
            OP_ROL: begin
                w_result = {a[WIDTH-2:0], a[WIDTH-1]};
                w_carry  = a[WIDTH-1];
            end
            OP_ROR: begin
                w_result = {a[0], a[WIDTH-1:1]};
                w_carry  = a[0];
            end
            OP_INC: begin
                w_result   = a + ONE;
                w_carry    = (a == ALL_ONES);
                w_overflow = (a == MAX_POS);
            end
            OP_DEC: begin
                w_result   = a - ONE;
                w_carry    = (a == '0);
                w_overflow = (a == MSB_ONLY);
            end
            OP_NOT:  w_result = ~a;
            OP_PASS: w_result = a;
            default: w_result = '0;
        endcase
    end

    // Flags are taken from the same combinational result that is being captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_result   <= w_result;
            r_carry    <= w_carry;
            r_zero     <= (w_result == '0);
            r_negative <= w_result[WIDTH-1];
            r_overflow <= w_overflow;
        end
    end

    assign alu_out  = r_result;
    assign carry    = r_carry;
    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and flags, checked one
// edge after each operation is applied, plus async reset behaviour.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .carry    (carry),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Packed as {result, carry, zero, negative, overflow}.
    function automatic logic [11:0] observed();
        return {alu_out, carry, zero, negative, overflow};
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed res=%h c=%b z=%b n=%b v=%b expected res=%h c=%b z=%b n=%b v=%b",
                     tag, obs[11:4], obs[3], obs[2], obs[1], obs[0],
                     exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] isel);
        @(negedge clk);
        a       = ia;
        b       = ib;
        alu_sel = isel;
    endtask

    task automatic addVec(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input logic [3:0] vs, input logic [7:0] vr,
                          input logic vc, input logic vz, input logic vn, input logic vv);
        vec_t t;
        t.name = nm; t.a = va; t.b = vb; t.sel = vs; t.res = vr;
        t.c = vc; t.z = vz; t.n = vn; t.v = vv;
        vecs.push_back(t);
    endtask

    initial begin
        logic [11:0] prevExp;
        logic [11:0] curExp;

        //      name         a      b      sel   res    c  z  n  v
        addVec("add_3_1",   8'h03, 8'h01, 4'h0, 8'h04, 0, 0, 0, 0);
        addVec("sub_6_2",   8'h06, 8'h02, 4'h1, 8'h04, 0, 0, 0, 0);
        addVec("add_ff_1",  8'hFF, 8'h01, 4'h0, 8'h00, 1, 1, 0, 0);
        addVec("add_7f_1",  8'h7F, 8'h01, 4'h0, 8'h80, 0, 0, 1, 1);
        addVec("add_80_80", 8'h80, 8'h80, 4'h0, 8'h00, 1, 1, 0, 1);
        addVec("and",       8'h0C, 8'h0A, 4'h2, 8'h08, 0, 0, 0, 0);
        addVec("or",        8'h0C, 8'h0A, 4'h3, 8'h0E, 0, 0, 0, 0);
        addVec("xor",       8'h0C, 8'h0A, 4'h4, 8'h06, 0, 0, 0, 0);
        addVec("nand",      8'h0C, 8'h0A, 4'h5, 8'hF7, 0, 0, 1, 0);
        addVec("nor",       8'h0C, 8'h0A, 4'h6, 8'hF1, 0, 0, 1, 0);
        addVec("xnor",      8'h0C, 8'h0A, 4'h7, 8'hF9, 0, 0, 1, 0);
        addVec("sub_0_1",   8'h00, 8'h01, 4'h1, 8'hFF, 1, 0, 1, 0);
        addVec("sub_80_1",  8'h80, 8'h01, 4'h1, 8'h7F, 0, 0, 0, 1);
        addVec("inc_ff",    8'hFF, 8'h33, 4'hC, 8'h00, 1, 1, 0, 0);
        addVec("inc_7f",    8'h7F, 8'h00, 4'hC, 8'h80, 0, 0, 1, 1);
        addVec("dec_80",    8'h80, 8'h00, 4'hD, 8'h7F, 0, 0, 0, 1);
        addVec("dec_0",     8'h00, 8'h00, 4'hD, 8'hFF, 1, 0, 1, 0);
        addVec("shl_81",    8'h81, 8'h55, 4'h8, 8'h02, 1, 0, 0, 0);
        addVec("shr_81",    8'h81, 8'h55, 4'h9, 8'h40, 1, 0, 0, 0);
        addVec("rol_81",    8'h81, 8'h55, 4'hA, 8'h03, 1, 0, 0, 0);
        addVec("ror_81",    8'h81, 8'h55, 4'hB, 8'hC0, 1, 0, 1, 0);
        addVec("not_81",    8'h81, 8'h55, 4'hE, 8'h7E, 0, 0, 0, 0);
        addVec("pass_81",   8'h81, 8'h55, 4'hF, 8'h81, 0, 0, 1, 0);
        addVec("shr_02",    8'h02, 8'h00, 4'h9, 8'h01, 0, 0, 0, 0);

        rst_n   = 1'b0;
        a       = 8'hFF;
        b       = 8'h01;
        alu_sel = 4'h0;
        #1;
        checkOutput("reset_initial", observed(), 12'h000);

        // Inputs toggle under reset; every output, including zero, must stay low.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'(8'h7F + i), 8'h01, 4'(i));
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold_%0d", i), observed(), 12'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h03; b = 8'h01; alu_sel = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("release_add", observed(), {8'h04, 4'b0000});

        // Back-to-back: new op every cycle, old result must hold until the edge.
        prevExp = {8'h04, 4'b0000};
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sel);
            #1;
            checkOutput({vecs[i].name, "_hold"}, observed(), prevExp);
            @(posedge clk);
            #1;
            curExp = {vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v};
            checkOutput(vecs[i].name, observed(), curExp);
            prevExp = curExp;
        end

        // Mid-stream asynchronous reset, asserted between clock edges.
        applyStimulus(8'hFF, 8'h01, 4'h0);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_add", observed(), {8'h00, 4'b1100});
        applyStimulus(8'h81, 8'h00, 4'hF);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_pass", observed(), {8'h81, 4'b0010});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", observed(), 12'h000);
        @(posedge clk);
        #1;
        checkOutput("async_reset_edge", observed(), 12'h000);

        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h7F; b = 8'h01; alu_sel = 4'h0;
        @(posedge clk);
        #1;
        checkOutput("release2_add", observed(), {8'h80, 4'b0011});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
